psum_collector: RTL

//  Sink for the ADDER output stream: takes Psum/Psum_valid beats and sums the
//  per-round partial sums of one output tile, lane by lane (1, 2 or 4 rounds
//  per wsize). Finished tiles go into a 2-entry buffer drained by a

---
 rtl/psum_pkg.sv | 29 ++
 rtl/psum_collector_if.sv | 27 ++
 rtl/psum_fifo.sv | 54 +++++
 rtl/psum_collector.sv | 127 ++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared constants and types for the partial-sum collector: wsize codes,
// round-count lookup, FSM states and default lane geometry.
package psum_pkg;

  localparam int LANES_DEF = 36;
  localparam int PW_DEF    = 24;
  localparam int ACC_W_DEF = 32;

  localparam logic [3:0] WS_3X3 = 4'd0;
  localparam logic [3:0] WS_5X5 = 4'd1;
  localparam logic [3:0] WS_7X7 = 4'd2;

  typedef enum logic {IDLE, ACCUM} state_t;

  // Reserved codes fall back to a single round; the caller flags them.
  function automatic logic [2:0] nrounds(input logic [3:0] ws);
    case (ws)
      WS_3X3:  return 3'd1;
      WS_5X5:  return 3'd2;
      WS_7X7:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic ws_reserved(input logic [3:0] ws);
    return ws > WS_7X7;
  endfunction

endpackage

// File: rtl/psum_collector_if.sv
// Psum input stream, flush, result valid/ready port and sticky error flags.
// master drives beats and consumes results; slave is the collector.
interface psum_collector_if #(
  parameter int LANES = 36,
  parameter int PW    = 24,
  parameter int ACC_W = 32
);
  logic [3:0]             wsize;
  logic                   Psum_valid;
  logic [LANES*PW-1:0]    Psum;
  logic                   clr;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] out_data;
  logic                   ovf_err;
  logic                   cfg_err;

  modport master (
    output wsize, Psum_valid, Psum, clr, out_ready,
    input  out_valid, out_data, ovf_err, cfg_err
  );

  modport slave (
    input  wsize, Psum_valid, Psum, clr, out_ready,
    output out_valid, out_data, ovf_err, cfg_err
  );
endinterface

// File: rtl/psum_fifo.sv
// Result buffer, DEPTH x W; head visible combinationally, zero when empty.
// Push on full is accepted only together with a pop; flush empties it.
module psum_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty && !flush;
  assign do_push  = push && !flush && (!full || do_pop);
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Sums 1/2/4 rounds of Psum beats per tile lane-wise into a 2-entry result buffer;
// result visible 1 cycle after the last beat; no input backpressure. PSUM_SAT_EN: saturating adds.
module psum_collector
  import psum_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int PW    = PW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  psum_collector_if.slave bus
);
  localparam int W = LANES*ACC_W;

  state_t       state_q, state_d;
  logic [2:0]   nrounds_q, nrounds_d, round_q, round_d, ws_rounds;
  logic [W-1:0] acc_q, acc_d, sum, head;
  logic         push, pop, full, empty, cfg_set, ovf_set;
  logic         ovf_err_q, cfg_err_q;

  assign ws_rounds = nrounds(bus.wsize);

  // Lane adders; in IDLE the base is forced to zero so a new tile never sees old acc.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PW-1:0]    p;
    logic signed [ACC_W-1:0] base, addend, lane_sum;

    assign p      = bus.Psum[i*PW +: PW];
    assign addend = ACC_W'(p);
    assign base   = (state_q == ACCUM) ? acc_q[i*ACC_W +: ACC_W] : '0;
`ifdef PSUM_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W:0] wide;

    assign wide = {base[ACC_W-1], base} + {addend[ACC_W-1], addend};
    always_comb begin
      lane_sum = wide[ACC_W-1:0];
      if (wide[ACC_W] != wide[ACC_W-1]) lane_sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end
`else
    assign lane_sum = base + addend;
`endif
    assign sum[i*ACC_W +: ACC_W] = lane_sum;
  end

  always_comb begin
    state_d   = state_q;
    nrounds_d = nrounds_q;
    round_d   = round_q;
    acc_d     = acc_q;
    push      = 1'b0;
    cfg_set   = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      round_d = '0;
      acc_d   = '0;
    end else if (bus.Psum_valid) begin
      case (state_q)
        IDLE: begin
          nrounds_d = ws_rounds;
          cfg_set   = ws_reserved(bus.wsize);
          if (ws_rounds == 3'd1) begin
            push = 1'b1;
          end else begin
            acc_d   = sum;
            round_d = 3'd1;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (round_q + 3'd1 == nrounds_q) begin
            push    = 1'b1;
            acc_d   = '0;
            round_d = '0;
            state_d = IDLE;
          end else begin
            acc_d   = sum;
            round_d = round_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop     = !empty && bus.out_ready;
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      nrounds_q <= 3'd1;
      round_q   <= '0;
      acc_q     <= '0;
      ovf_err_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nrounds_q <= nrounds_d;
      round_q   <= round_d;
      acc_q     <= acc_d;
      ovf_err_q <= ovf_err_q | ovf_set;
      cfg_err_q <= cfg_err_q | cfg_set;
    end
  end

  psum_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.clr),
    .push     (push),
    .push_dat (sum),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head_dat (head)
  );

  assign bus.out_valid = !empty;
  assign bus.out_data  = head;
  assign bus.ovf_err   = ovf_err_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule
